key_pulse_gen: RTL
==================

# key_pulse_gen

Converts the byte stream from the PS/2 scancode receiver into the single-cycle move pulses consumed by the game controller (`key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop`). It decodes Set-2 make/break/extended prefixes and tracks which game keys are held. It produces one pulse per press, plus frame-timed auto-repeat for the movement keys. It sits between the PS/2 receiver and the game FSM, clocked on the system clock and paced by the 60 Hz game tick.

## Interface
- `DAS_FRAMES`, 16: ticks from press to first auto-repeat of left/right.
- `ARR_FRAMES`, 6: ticks between subsequent left/right repeats.
- `SOFT_FRAMES`, 2: ticks between repeats of down. There is no initial delay; the first repeat comes after `SOFT_FRAMES` ticks.
- All parameters are 1..63.

- `clk`  in  1  system clock
- `rst`  in  1  reset: synchronous, active-high; clock clk
- `scan_code`  in  8  received byte; valid only with `scan_valid`
- `scan_valid`  in  1  one-cycle strobe per received byte
- `tick_game`  in  1  one-cycle 60 Hz frame strobe
- `key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop`  out  1 each  single-cycle registered pulses
- `held`  out  5  held-key mask {drop, rotate, down, right, left}, registered

## Operation
- Parser FSM states: P_IDLE, P_E0, P_F0, P_E0F0. Transitions occur only on `scan_valid`.
  - From P_IDLE: byte E0 goes to P_E0; byte F0 goes to P_F0.
  - From P_E0: byte F0 goes to P_E0F0; byte E0 stays in P_E0.
  - Any other byte completes a code and returns the FSM to P_IDLE.
- Key map:
  - Left arrow = E0 6B
  - Right arrow = E0 74
  - Down arrow = E0 72
  - Up arrow (rotate) = E0 75
  - Space (drop) = 29, non-extended
- Extended-ness must match: a non-extended 6B (keypad 4) is ignored, and so is an extended 29.
- Unmapped codes (including E0 12) return the FSM to P_IDLE with no effect.
- Make of a key whose `held` bit is 0:
  - set the `held` bit;
  - pulse that key's output;
  - clear that key's frame counter.
- Make of a key already held (the keyboard's own typematic resend) is ignored: no pulse, no counter change.
- Break: clear the `held` bit and the counter. No pulse.
- Auto-repeat applies to left, right and down only. Each has a 6-bit frame counter.
  - On `tick_game` while held, the counter increments.
  - Left/right: when the incremented value equals the current threshold, pulse the key and reset the counter to 0. The threshold is `DAS_FRAMES` before the first repeat and `ARR_FRAMES` after it. A per-key `repeating` flag, cleared on press and break, selects the threshold.
  - Down: the threshold is always `SOFT_FRAMES`.
- Rotate and drop never repeat. Re-pressing them requires a break first.
- Keys are independent. Left and right held together each pulse on their own schedule; arbitration is the game controller's job.

## Timing
- Reset values: all outputs 0, `held` = 0, counters 0, `repeating` flags 0, parser in P_IDLE.
- Press latency: a pulse is high exactly one cycle, the cycle after the `scan_valid` that completes the make code.
- Repeat latency: a pulse is high exactly one cycle, the cycle after the qualifying `tick_game`.
- `scan_valid` and `tick_game` in the same cycle:
  - The byte is processed.
  - If that byte is a make or break of key K, K's counter takes the press/break value and that tick is not counted for K.
  - Other keys count the tick normally.
- At most one pulse per key per cycle.
- Back-to-back `scan_valid` on consecutive cycles must be handled with no byte lost.
- Reset asserted mid-sequence (e.g. after E0) discards the partial code. Any key held at that moment must produce a fresh make before it pulses again.
- Counters never wrap. Thresholds are at most 63, and a counter resets when it reaches its threshold.

## Test plan
- Bytes E0, 6B, then 10 ticks, then E0 F0 6B: exactly one `key_left` pulse, 1 cycle after the 6B strobe. `held[0]` = 1 from that point until the cycle after the final 6B.
- Hold right (E0 74) for 40 ticks: pulses at press, then after ticks 16, 22, 28, 34 and 40 (6 pulses total). After break plus re-press, the first repeat is again at tick 16.
- Hold down (E0 72) for 10 ticks: pulses at press, then after ticks 2, 4, 6, 8 and 10. Resent make bytes E0 72 mid-hold cause no extra pulse and no counter reset.
- Space make 29 sent 3 times, then F0 29, then 29: exactly two `key_drop` pulses. Non-extended 6B and E0 29 give no pulses and leave `held` = 0.
- Make E0 75 arriving in the same cycle as `tick_game`: one `key_rotate` pulse. With left already held at count 15, the same tick still fires the left repeat.
- Bytes E0 then reset, then 6B: no `key_left` pulse and `held` = 0. Left held at reset: no pulses until a new E0 6B arrives.

Source files
------------

// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if
// Bundles the signals between the PS/2 scancode receiver, the frame timer and
// the game controller around key_pulse_gen.
//   scan_code  [7:0] received Set-2 byte, meaningful only with scan_valid
//   scan_valid       one-cycle strobe per received byte
//   tick_game        one-cycle 60 Hz frame strobe
//   key_left/right/down/rotate/drop  single-cycle move pulses
//   held       [4:0] held-key mask {drop, rotate, down, right, left}
// The slave modport is the decoder's view; master is the environment's view.
interface key_pulse_gen_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       tick_game;
    logic       key_left;
    logic       key_right;
    logic       key_down;
    logic       key_rotate;
    logic       key_drop;
    logic [4:0] held;

    modport master (
        output scan_code, scan_valid, tick_game,
        input  key_left, key_right, key_down, key_rotate, key_drop, held
    );

    modport slave (
        input  scan_code, scan_valid, tick_game,
        output key_left, key_right, key_down, key_rotate, key_drop, held
    );
endinterface

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
// Turns the PS/2 Set-2 byte stream into single-cycle game move pulses.
// A four-state parser recognises make, break and E0-extended codes; five game
// keys are tracked as held, each fresh press emits one pulse, and left/right/
// down auto-repeat on game ticks (DAS then ARR for left/right, SOFT for down).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  key_pulse_gen_if.slave: scan_code/scan_valid/tick_game in,
//        key_* pulses and held mask out (all outputs registered)
module key_pulse_gen #(
    parameter int unsigned DAS_FRAMES  = 16,
    parameter int unsigned ARR_FRAMES  = 6,
    parameter int unsigned SOFT_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst,
    key_pulse_gen_if.slave  bus
);

    localparam logic [5:0] DAS_T  = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_T  = 6'(ARR_FRAMES);
    localparam logic [5:0] SOFT_T = 6'(SOFT_FRAMES);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        P_IDLE,
        P_E0,
        P_F0,
        P_E0F0
    } pstate_t;

    pstate_t    state_q, state_d;
    logic       code_done;
    logic       code_ext;
    logic       code_brk;
    logic [4:0] key_hit;
    logic [4:0] press;
    logic [4:0] release_k;

    logic [4:0] held_q, held_d;
    logic [4:0] pulse_q, pulse_d;
    logic [1:0] rep_q, rep_d;
    logic [5:0] cnt_q [3];
    logic [5:0] cnt_d [3];
    logic [5:0] thr   [3];
    logic [6:0] inc   [3];
    logic [2:0] fire;

    // Parser: consumes one byte per scan_valid, flags a completed code
    always_comb begin
        state_d   = state_q;
        code_done = 1'b0;
        code_ext  = 1'b0;
        code_brk  = 1'b0;
        if (bus.scan_valid) begin
            case (state_q)
                P_IDLE: begin
                    if (bus.scan_code == B_EXT) begin
                        state_d = P_E0;
                    end else if (bus.scan_code == B_BREAK) begin
                        state_d = P_F0;
                    end else begin
                        state_d   = P_IDLE;
                        code_done = 1'b1;
                    end
                end
                P_E0: begin
                    // A repeated E0 prefix keeps waiting for the real code.
                    if (bus.scan_code == B_BREAK) begin
                        state_d = P_E0F0;
                    end else if (bus.scan_code != B_EXT) begin
                        state_d   = P_IDLE;
                        code_done = 1'b1;
                        code_ext  = 1'b1;
                    end
                end
                P_F0: begin
                    state_d   = P_IDLE;
                    code_done = 1'b1;
                    code_brk  = 1'b1;
                end
                P_E0F0: begin
                    state_d   = P_IDLE;
                    code_done = 1'b1;
                    code_ext  = 1'b1;
                    code_brk  = 1'b1;
                end
                default: state_d = P_IDLE;
            endcase
        end
    end

    // Key map: extended-ness must match exactly, everything else is dropped
    always_comb begin
        key_hit = 5'b0;
        if (code_done) begin
            if (code_ext) begin
                case (bus.scan_code)
                    8'h6B:   key_hit[0] = 1'b1;
                    8'h74:   key_hit[1] = 1'b1;
                    8'h72:   key_hit[2] = 1'b1;
                    8'h75:   key_hit[3] = 1'b1;
                    default: key_hit    = 5'b0;
                endcase
            end else if (bus.scan_code == 8'h29) begin
                key_hit[4] = 1'b1;
            end
        end
    end

    // Typematic resends of an already-held key are not presses.
    assign press     = code_brk ? 5'b0 : (key_hit & ~held_q);
    assign release_k = code_brk ? key_hit : 5'b0;

    // Repeat timing: a press/break in the same cycle as a tick overrides the tick
    always_comb begin
        thr[0] = rep_q[0] ? ARR_T : DAS_T;
        thr[1] = rep_q[1] ? ARR_T : DAS_T;
        thr[2] = SOFT_T;
        fire   = 3'b0;
        rep_d  = rep_q;
        for (int k = 0; k < 3; k++) begin
            inc[k]   = {1'b0, cnt_q[k]} + 7'd1;
            cnt_d[k] = cnt_q[k];
            if (press[k] || release_k[k]) begin
                cnt_d[k] = 6'd0;
            end else if (bus.tick_game && held_q[k]) begin
                if (inc[k] == {1'b0, thr[k]}) begin
                    fire[k]  = 1'b1;
                    cnt_d[k] = 6'd0;
                end else begin
                    cnt_d[k] = inc[k][5:0];
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (press[k] || release_k[k]) begin
                rep_d[k] = 1'b0;
            end else if (fire[k]) begin
                rep_d[k] = 1'b1;
            end
        end
        held_d  = (held_q | press) & ~release_k;
        pulse_d = press | {2'b00, fire};
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= P_IDLE;
            held_q  <= 5'b0;
            pulse_q <= 5'b0;
            rep_q   <= 2'b0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= 6'd0;
            end
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            rep_q   <= rep_d;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.key_left   = pulse_q[0];
    assign bus.key_right  = pulse_q[1];
    assign bus.key_down   = pulse_q[2];
    assign bus.key_rotate = pulse_q[3];
    assign bus.key_drop   = pulse_q[4];
    assign bus.held       = held_q;

endmodule
